seg_capture: RTL and testbench
==============================

Name: seg_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment anode/cathode drive.
- Samples the time-multiplexed anode and cathode lines, filters digit-transition ghosting and decodes each lit pattern back to a hex nibble.
- Assembles the four digits into a 16-bit value and flags each complete frame.
- Used for board loopback checks and as a bench monitor for the display path.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required before a digit dwell is accepted (legal range 2..255).
- TIMEOUT, 1048576: cycles without a complete frame before `lost` asserts.
- TIMEOUT_W, 21: width of the timeout counter. Must satisfy 2**TIMEOUT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seg_anode  in  4  digit enables, active-low; bit 0 = rightmost digit
- seg_cathode  in  7  segments {g,f,e,d,c,b,a}, active-low
- value  out  16  last complete frame; anode bit i maps to value[4i+3:4i]
- frame_valid  out  1  one-cycle pulse when `value` updates
- frame_err  out  1  valid with frame_valid; 1 if any digit in that frame was undecodable
- lost  out  1  high while no frame has completed for TIMEOUT cycles

Behaviour:
- Reset: value=0, frame_valid=0, frame_err=0, lost=0. Also clears the input register, stability counter, seen[3:0], err[3:0], digit buffer and timeout counter. A reset asserted mid-frame discards the partial frame.
- Input stage: seg_anode and seg_cathode are registered once. All logic below operates on the registered pair, called `pat`.
- Digit select: pat anode must be one-hot-low (exactly one bit 0).
  - All-high (blank) or more than one low: no digit is selected and stab_cnt is forced to 0.
  - This case is not an error.
- Dwell state machine, states SETTLE and HELD:
  - SETTLE: stab_cnt increments while `pat` equals the previous `pat` and a digit is selected. Any change resets stab_cnt to 0.
  - When stab_cnt reaches STABLE_CYCLES-1 (i.e. STABLE_CYCLES identical samples), the dwell is accepted for one cycle and the FSM moves to HELD.
  - HELD: no further accepts. Any change of `pat`, or loss of selection, returns to SETTLE with stab_cnt=0.
  - Result: exactly one accept per dwell, regardless of dwell length.
- Decode: standard hex patterns, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern decodes to nibble 0 and sets err[i].
- Accept of digit i:
  - Writes buf[i] and sets seen[i].
  - err[i] is overwritten with the decode status.
  - A repeat accept of the same i before the frame completes overwrites buf[i] and err[i]; the latest value wins.
  - Digits may arrive in any order.
- Frame completion: on the cycle after an accept makes seen==4'b1111:
  - value <= buf, frame_valid=1, frame_err=|err, lost=0.
  - seen and err cleared; timeout counter cleared.
- Timeout:
  - Counter increments every cycle, saturating at TIMEOUT-1.
  - lost=1 on the cycle after the counter reaches TIMEOUT-1; it stays high until the next frame completion.
  - If frame completion and timeout occur in the same cycle, completion wins: lost stays 0 and the counter clears.
- The value output holds between frames. frame_err is meaningful only while frame_valid=1 and is 0 otherwise.

Test Plan:
1. STABLE_CYCLES=4. Drive digits 0..3 with patterns for 4,3,2,1, 8 cycles each, anode 1110,1101,1011,0111 -> single frame_valid pulse, value=16'h1234, frame_err=0, occurring 1 cycle after the 4th accept.
2. Hold anode 1110 with pattern "7" for only 3 cycles between blanks, then complete the other three digits -> no frame_valid until a ≥4-cycle dwell on digit 0. Then value[3:0]=7.
3. Two anodes low (1100) with a valid pattern for 20 cycles -> no accept, seen unchanged, frame_err=0.
4. Frame with digit 2 cathode=1111111 (blank segments) -> frame_valid with value[11:8]=0 and frame_err=1. The next clean frame -> frame_err=0.
5. TIMEOUT=64, inputs held all-high -> lost=1 after 64 cycles. A subsequent complete frame -> lost=0 in the same cycle as frame_valid.
6. Assert rst after digits 0 and 1 are accepted, then send digits 2 and 3 only -> no frame_valid, value=0. After digits 0 and 1 are sent again -> frame_valid.

Source files
------------

// File: rtl/seg_capture.sv
// ---------------------------------------------------------------------------
// seg_capture
//   Receive side of a multiplexed 7-segment display drive. Samples the
//   time-multiplexed anode/cathode lines, waits for each digit dwell to
//   settle (rejecting ghosting between digits), decodes the lit pattern to a
//   hex nibble and assembles four digits into a 16-bit frame.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   seg_anode    digit enables, active-low, bit 0 = rightmost digit
//   seg_cathode  segments {g,f,e,d,c,b,a}, active-low
//   value        last complete frame, anode bit i -> value[4i+3:4i]
//   frame_valid  one-cycle pulse when value updates
//   frame_err    with frame_valid: some digit of that frame was undecodable
//   lost         high while no frame has completed for TIMEOUT cycles
// ---------------------------------------------------------------------------
module seg_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 1048576,
  parameter int TIMEOUT_W     = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_anode,
  input  logic [6:0]  seg_cathode,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        lost
);

  typedef enum logic {SETTLE, HELD} state_t;

  localparam logic [7:0]           STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_ONE   = TIMEOUT_W'(1);

  // Returns {err, nibble}; unknown patterns give nibble 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] c);
    case (c)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  // Registered input pair (pat) and the pair from the cycle before.
  logic [3:0]           anode_q, anode_d, prev_anode_q, prev_anode_d;
  logic [6:0]           cathode_q, cathode_d, prev_cathode_q, prev_cathode_d;
  state_t               state_q, state_d;
  logic [7:0]           stab_cnt_q, stab_cnt_d;
  logic [3:0]           seen_q, seen_d;
  logic [3:0]           err_q, err_d;
  logic [15:0]          dig_buf_q, dig_buf_d;
  logic [15:0]          value_q, value_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 lost_q, lost_d;

  logic                 sel;
  logic [1:0]           idx;
  logic                 same;
  logic                 accept;
  logic                 frame_done;
  logic [4:0]           dec;
  logic [7:0]           stab_inc;

  // Digit select: exactly one anode low. Blank or multi-low selects nothing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sel = 1'b0;
    idx = 2'd0;
    case (anode_q)
      4'b1110: begin sel = 1'b1; idx = 2'd0; end
      4'b1101: begin sel = 1'b1; idx = 2'd1; end
      4'b1011: begin sel = 1'b1; idx = 2'd2; end
      4'b0111: begin sel = 1'b1; idx = 2'd3; end
      default: begin sel = 1'b0; idx = 2'd0; end
    endcase
  end

  assign same     = ({anode_q, cathode_q} == {prev_anode_q, prev_cathode_q});
  assign stab_inc = stab_cnt_q + 8'd1;
  assign dec      = decode(cathode_q);

  // Dwell FSM: one accept after STABLE_CYCLES identical samples, then hold
  // off until the pattern changes or selection is lost.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    accept     = 1'b0;
    if (!sel || !same) begin
      state_d    = SETTLE;
      stab_cnt_d = 8'd0;
    end else if (state_q == SETTLE) begin
      stab_cnt_d = stab_inc;
      if (stab_inc == STAB_LAST) begin
        accept  = 1'b1;
        state_d = HELD;
      end
    end
  end

  // Digit assembly, frame completion and timeout.
  always_comb begin
    anode_d        = seg_anode;
    cathode_d      = seg_cathode;
    prev_anode_d   = anode_q;
    prev_cathode_d = cathode_q;
    seen_d         = seen_q;
    err_d          = err_q;
    dig_buf_d      = dig_buf_q;
    value_d        = value_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = 1'b0;
    tmo_cnt_d      = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + TMO_ONE;
    lost_d         = lost_q | (tmo_cnt_q == TMO_LAST);

    if (accept) begin
      seen_d[idx]                    = 1'b1;
      err_d[idx]                     = dec[4];
      dig_buf_d[{idx, 2'b00} +: 4]   = dec[3:0];
    end

    // Completion is decided on the accept itself so the frame appears on
    // the very next cycle; it also overrides a coincident timeout.
    frame_done = accept && (seen_d == 4'hF);
    if (frame_done) begin
      value_d       = dig_buf_d;
      frame_valid_d = 1'b1;
      frame_err_d   = |err_d;
      seen_d        = 4'h0;
      err_d         = 4'h0;
      tmo_cnt_d     = '0;
      lost_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      anode_q        <= 4'h0;
      cathode_q      <= 7'h0;
      prev_anode_q   <= 4'h0;
      prev_cathode_q <= 7'h0;
      state_q        <= SETTLE;
      stab_cnt_q     <= 8'd0;
      seen_q         <= 4'h0;
      err_q          <= 4'h0;
      // NOTE: the digit buffer is plain flops, so it is cleared with
      // everything else; a partial frame never survives reset.
      dig_buf_q      <= 16'h0;
      value_q        <= 16'h0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
      tmo_cnt_q      <= '0;
      lost_q         <= 1'b0;
    end else begin
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
      prev_anode_q   <= prev_anode_d;
      prev_cathode_q <= prev_cathode_d;
      state_q        <= state_d;
      stab_cnt_q     <= stab_cnt_d;
      seen_q         <= seen_d;
      err_q          <= err_d;
      dig_buf_q      <= dig_buf_d;
      value_q        <= value_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
      lost_q         <= lost_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign lost        = lost_q;

endmodule

// File: tb/tb_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_seg_capture
//   Directed bench for seg_capture with STABLE_CYCLES=4, TIMEOUT=64.
//   Table of whole frames plus hand sequences for short dwells, multi-low
//   anodes, held dwells, timeout and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  seg_anode = 4'hF;
  logic [6:0]  seg_cathode = 7'h7F;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic        lost;

  seg_capture #(
    .STABLE_CYCLES(4),
    .TIMEOUT      (64),
    .TIMEOUT_W    (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_anode  (seg_anode),
    .seg_cathode(seg_cathode),
    .value      (value),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [27:0] cath;      // digit i cathode at [7i+6:7i]
    logic [15:0] exp_value;
    logic        exp_err;
  } frame_vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Frame monitor, sampled 1 time unit after the active edge.
  int          fv_count = 0;
  logic [15:0] fv_value = 16'h0;
  logic        fv_err   = 1'b0;
  logic        fv_lost  = 1'b0;

  always @(posedge clk) begin
    #1;
    if (frame_valid) begin
      fv_count = fv_count + 1;
      fv_value = value;
      fv_err   = frame_err;
      fv_lost  = lost;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Dwell n cycles on digit i, then two blank cycles.
  task automatic send_digit(input int i, input logic [6:0] c, input int n);
    logic [3:0] an;
    an = 4'hF;
    an[i] = 1'b0;
    seg_anode = an;
    seg_cathode = c;
    repeat (n) @(negedge clk);
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [27:0] cath);
    for (int i = 0; i < 4; i++) send_digit(i, cath[7*i +: 7], 8);
  endtask

  frame_vec_t vecs [5];

  initial begin
    int          fv0;
    logic [7:0]  obs;

    vecs[0] = '{cath: {SEG[1], SEG[2], SEG[3], SEG[4]},     exp_value: 16'h1234, exp_err: 1'b0};
    vecs[1] = '{cath: {SEG[13], SEG[12], SEG[11], SEG[10]}, exp_value: 16'hDCBA, exp_err: 1'b0};
    vecs[2] = '{cath: {SEG[5], 7'h7F, SEG[6], SEG[7]},      exp_value: 16'h5067, exp_err: 1'b1};
    vecs[3] = '{cath: {SEG[15], SEG[14], SEG[9], SEG[8]},   exp_value: 16'hFE98, exp_err: 1'b0};
    vecs[4] = '{cath: {SEG[0], SEG[0], SEG[0], 7'b1010101}, exp_value: 16'h0000, exp_err: 1'b1};

    // Reset state
    do_reset();
    check("reset_value", 32'(value), 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_lost", 32'(lost), 32'h0);

    // Basic frame with exact pulse timing on the last digit
    fv0 = fv_count;
    send_digit(0, SEG[4], 8);
    send_digit(1, SEG[3], 8);
    send_digit(2, SEG[2], 8);
    seg_anode = 4'b0111;
    seg_cathode = SEG[1];
    obs = 8'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      obs[k] = frame_valid;
      if (k == 4) check("t1_value_at_pulse", 32'(value), 32'h1234);
    end
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    repeat (2) @(negedge clk);
    check("t1_pulse_timing", 32'(obs), 32'h10);
    check("t1_frame_count", 32'(fv_count - fv0), 32'd1);
    check("t1_frame_err", 32'(fv_err), 32'h0);

    // Table of complete frames
    for (int v = 0; v < 5; v++) begin
      fv0 = fv_count;
      send_frame(vecs[v].cath);
      check($sformatf("tab%0d_count", v), 32'(fv_count - fv0), 32'd1);
      check($sformatf("tab%0d_value", v), 32'(fv_value), 32'(vecs[v].exp_value));
      check($sformatf("tab%0d_err", v), 32'(fv_err), 32'(vecs[v].exp_err));
      check($sformatf("tab%0d_err_idle", v), 32'(frame_err), 32'h0);
    end

    // Short 3-cycle dwell on digit 0 is ignored
    fv0 = fv_count;
    send_digit(0, SEG[7], 3);
    send_digit(1, SEG[3], 8);
    send_digit(2, SEG[2], 8);
    send_digit(3, SEG[1], 8);
    check("t2_no_frame_short_dwell", 32'(fv_count - fv0), 32'd0);
    send_digit(0, SEG[7], 8);
    check("t2_frame_after_dwell", 32'(fv_count - fv0), 32'd1);
    check("t2_value", 32'(fv_value), 32'h1237);

    // Two anodes low selects nothing
    fv0 = fv_count;
    send_digit(1, SEG[3], 8);
    send_digit(2, SEG[2], 8);
    seg_anode = 4'b1100;
    seg_cathode = SEG[14];
    repeat (20) @(negedge clk);
    seg_anode = 4'hF;
    seg_cathode = 7'h7F;
    repeat (2) @(negedge clk);
    send_digit(3, SEG[1], 8);
    check("t3_no_frame_multi_low", 32'(fv_count - fv0), 32'd0);
    send_digit(0, SEG[4], 8);
    check("t3_frame_count", 32'(fv_count - fv0), 32'd1);
    check("t3_value", 32'(fv_value), 32'h1234);
    check("t3_err", 32'(fv_err), 32'h0);

    // Overwrite of a repeated digit, and a long dwell accepts only once
    fv0 = fv_count;
    send_digit(0, SEG[5], 8);
    send_digit(0, SEG[6], 8);
    send_digit(1, SEG[10], 8);
    send_digit(2, SEG[11], 8);
    send_digit(3, SEG[9], 30);
    check("t4_overwrite_count", 32'(fv_count - fv0), 32'd1);
    check("t4_overwrite_value", 32'(fv_value), 32'h9BA6);
    send_digit(0, SEG[1], 8);
    send_digit(1, SEG[1], 8);
    send_digit(2, SEG[1], 8);
    check("t4_long_dwell_single_accept", 32'(fv_count - fv0), 32'd1);
    send_digit(3, SEG[2], 8);
    check("t4_next_frame_count", 32'(fv_count - fv0), 32'd2);
    check("t4_next_value", 32'(fv_value), 32'h2111);

    // Timeout: lost rises 64 cycles after reset with blank inputs
    do_reset();
    repeat (63) @(negedge clk);
    check("t5_lost_before", 32'(lost), 32'h0);
    @(negedge clk);
    check("t5_lost_after", 32'(lost), 32'h1);
    fv0 = fv_count;
    send_digit(0, SEG[4], 8);
    send_digit(1, SEG[3], 8);
    send_digit(2, SEG[2], 8);
    check("t5_lost_held", 32'(lost), 32'h1);
    send_digit(3, SEG[1], 8);
    check("t5_frame_count", 32'(fv_count - fv0), 32'd1);
    check("t5_lost_at_pulse", 32'(fv_lost), 32'h0);
    check("t5_lost_after_frame", 32'(lost), 32'h0);

    // Reset mid-frame discards partial digits
    do_reset();
    fv0 = fv_count;
    send_digit(0, SEG[4], 8);
    send_digit(1, SEG[3], 8);
    do_reset();
    send_digit(2, SEG[2], 8);
    send_digit(3, SEG[1], 8);
    check("t6_no_frame", 32'(fv_count - fv0), 32'd0);
    check("t6_value_zero", 32'(value), 32'h0);
    send_digit(0, SEG[4], 8);
    send_digit(1, SEG[3], 8);
    check("t6_frame_count", 32'(fv_count - fv0), 32'd1);
    check("t6_value", 32'(fv_value), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
